// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
//   I2C bus master that runs a single 16-bit register write or read per
//   request, addressed by an 8-bit register pointer in the slave at DEV_ADDR.
//   SDA is split into oSDA (master drive, 1 = released) and iSDA (slave
//   drive) to model the open-drain wire.
// Ports
//   CLK, Reset        clock (rising edge), async active-low reset
//   start             request, sampled only while idle
//   rnw               1 = read, 0 = write (captured with start)
//   reg_addr          register pointer (captured with start)
//   wr_data           write word, MSB byte first (captured with start)
//   iSDA              SDA as driven by the slave (ACK / read data)
//   SCL, oSDA         bus clock and master SDA drive
//   rd_data           read word, updated only by an error-free read
//   busy              high from the cycle after accept up to the done cycle
//   done              one-cycle end-of-transaction pulse
//   ack_err           slave NACK seen; held until the next accepted start
module i2c_master_ctrl #(
  parameter int         CLK_DIV  = 4,
  parameter logic [6:0] DEV_ADDR = 7'h22
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic        rnw,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] wr_data,
  input  logic        iSDA,
  output logic        SCL,
  output logic        oSDA,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
  localparam logic [CW-1:0] MID       = CW'(CLK_DIV + CLK_DIV / 2);
  localparam logic [CW-1:0] LAST      = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(2 * CLK_DIV - 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_TX     = 3'd2;
  localparam logic [2:0] S_ACKRX  = 3'd3;
  localparam logic [2:0] S_RSTART = 3'd4;
  localparam logic [2:0] S_RX     = 3'd5;
  localparam logic [2:0] S_ACKTX  = 3'd6;
  localparam logic [2:0] S_STOP   = 3'd7;

  logic [2:0]    state;
  logic [CW-1:0] cnt;       // cycle within the current bit period
  logic [3:0]    bit_cnt;   // 7..0, MSB first
  logic [2:0]    byte_cnt;  // selects the phase of the transaction
  logic [7:0]    tx_byte;
  logic [15:0]   rx_sh;     // both read bytes shift through here
  logic          rnw_q;
  logic [7:0]    reg_q;
  logic [15:0]   wd_q;
  logic          bit_end;
  logic          scl_hi;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_byte  <= '0;
      rx_sh    <= '0;
      rnw_q    <= 1'b0;
      reg_q    <= '0;
      wd_q     <= '0;
      rd_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: if (start) begin
          rnw_q    <= rnw;
          reg_q    <= reg_addr;
          wd_q     <= wr_data;
          ack_err  <= 1'b0;
          busy     <= 1'b1;
          byte_cnt <= '0;
          cnt      <= '0;
          state    <= S_START;
        end
        S_START, S_RSTART: if (bit_end) begin
          state   <= S_TX;
          bit_cnt <= 4'd7;
          // Address byte: R/W bit is 1 only after the repeated START.
          tx_byte <= {DEV_ADDR, state == S_RSTART};
        end
        S_TX: if (bit_end) begin
          if (bit_cnt == 4'd0) state <= S_ACKRX;
          else bit_cnt <= bit_cnt - 4'd1;
        end
        S_ACKRX: if (bit_end) begin
          if (iSDA) begin
            ack_err <= 1'b1;
            state   <= S_STOP;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
            bit_cnt  <= 4'd7;
            case (byte_cnt)
              3'd0: begin
                state   <= S_TX;
                tx_byte <= reg_q;
              end
              3'd1: if (rnw_q) state <= S_RSTART;
                    else begin
                      state   <= S_TX;
                      tx_byte <= wd_q[15:8];
                    end
              3'd2: if (rnw_q) state <= S_RX;
                    else begin
                      state   <= S_TX;
                      tx_byte <= wd_q[7:0];
                    end
              default: state <= S_STOP;
            endcase
          end
        end
        S_RX: if (bit_end) begin
          rx_sh <= {rx_sh[14:0], iSDA};
          if (bit_cnt == 4'd0) state <= S_ACKTX;
          else bit_cnt <= bit_cnt - 4'd1;
        end
        S_ACKTX: if (bit_end) begin
          if (byte_cnt == 3'd3) begin
            byte_cnt <= 3'd4;
            bit_cnt  <= 4'd7;
            state    <= S_RX;
          end else begin
            rd_data <= rx_sh;
            state   <= S_STOP;
          end
        end
        // STOP is one cycle short: its final cycle is the idle/done cycle,
        // where the bus already shows SCL=1, SDA=1.
        S_STOP: if (cnt == STOP_LAST) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus pins decode straight from registered state so that an async reset
  // releases the bus in the same cycle.
  always_comb begin
    scl_hi = (cnt >= HALF);
    SCL    = 1'b1;
    oSDA   = 1'b1;
    case (state)
      S_START, S_RSTART: begin
        // Low half with SDA released, then SDA falls mid high half.
        SCL  = scl_hi;
        oSDA = (cnt < MID);
      end
      S_TX: begin
        SCL  = scl_hi;
        oSDA = tx_byte[bit_cnt[2:0]];
      end
      S_ACKRX, S_RX: SCL = scl_hi;
      S_ACKTX: begin
        SCL  = scl_hi;
        oSDA = (byte_cnt == 3'd4);  // ACK after byte1, NACK after byte0
      end
      S_STOP: begin
        SCL  = scl_hi;
        oSDA = (cnt >= MID);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C register slave.
module tb_i2c_master_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic        rnw;
  logic [7:0]  reg_addr;
  logic [15:0] wr_data;
  logic        sl_sda;
  logic        SCL, oSDA, busy, done, ack_err;
  logic [15:0] rd_data;

  i2c_master_ctrl #(.CLK_DIV(4), .DEV_ADDR(7'h22)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .rnw(rnw), .reg_addr(reg_addr),
    .wr_data(wr_data), .iSDA(sl_sda), .SCL(SCL), .oSDA(oSDA),
    .rd_data(rd_data), .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 CLK = ~CLK;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural slave ----------------
  // Bus log codes: 256 = START, 512 = STOP, 768+b = master ACK bit, else byte.
  int          blog[$];
  int          exp_log[$];
  logic [15:0] regs [256];
  bit          nack_addr = 1'b0;
  bit          s_scl, s_sda, scl_q = 1'b1, sda_q = 1'b1;
  int          ph = 0, bitn = 0, bidx = 0;
  bit          sel = 1'b0, rw = 1'b0, mack = 1'b1;
  logic [7:0]  sh = '0, ptr = '0, hi = '0;
  logic [15:0] txw = '0;

  initial sl_sda = 1'b1;

  always @(negedge CLK) begin
    s_scl = SCL;
    s_sda = oSDA & sl_sda;
    if (!Reset) begin
      ph = 0; bitn = 0; sl_sda = 1'b1;
    end else if (s_scl && scl_q && sda_q && !s_sda) begin
      blog.push_back(256); ph = 0; bitn = 0; bidx = 0; sl_sda = 1'b1;
    end else if (s_scl && scl_q && !sda_q && s_sda) begin
      blog.push_back(512); ph = 0; bitn = 0; sl_sda = 1'b1;
    end else if (s_scl && !scl_q) begin
      if (ph == 0) begin sh = {sh[6:0], s_sda}; bitn++; end
      else if (ph == 3) begin mack = s_sda; blog.push_back(768 + int'(s_sda)); end
    end else if (!s_scl && scl_q) begin
      case (ph)
        0: if (bitn == 8) begin
          blog.push_back(int'(sh));
          if (bidx == 0) begin
            sel = (sh[7:1] == 7'h22) && !nack_addr;
            rw  = sh[0];
          end else if (sel && !rw) begin
            if (bidx == 1) ptr = sh;
            else if (bidx == 2) hi = sh;
            else if (bidx == 3) regs[ptr] = {hi, sh};
          end
          sl_sda = sel ? 1'b0 : 1'b1;
          bidx++;
          ph = 1;
        end
        1: if (sel && rw && bidx == 1) begin
          ph = 2; bitn = 0; txw = regs[ptr];
          sl_sda = txw[15]; txw = {txw[14:0], 1'b0};
        end else begin
          ph = 0; bitn = 0; sl_sda = 1'b1;
        end
        2: begin
          bitn++;
          if (bitn == 8) begin ph = 3; sl_sda = 1'b1; end
          else begin sl_sda = txw[15]; txw = {txw[14:0], 1'b0}; end
        end
        default: if (!mack) begin
          ph = 2; bitn = 0; sl_sda = txw[15]; txw = {txw[14:0], 1'b0};
        end else begin
          ph = 0; bitn = 0; sl_sda = 1'b1;
        end
      endcase
    end
    scl_q = s_scl;
    sda_q = s_sda;
  end

  // ---------------- helpers ----------------
  function automatic bit log_ok();
    if (blog.size() != exp_log.size()) return 1'b0;
    foreach (exp_log[i]) if (blog[i] != exp_log[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic build_exp(input bit r, input logic [7:0] ra, input logic [15:0] wd, input bit nk);
    exp_log.delete();
    exp_log.push_back(256);
    exp_log.push_back('h44);
    if (nk) exp_log.push_back(512);
    else if (!r) begin
      exp_log.push_back(int'(ra)); exp_log.push_back(int'(wd[15:8]));
      exp_log.push_back(int'(wd[7:0])); exp_log.push_back(512);
    end else begin
      exp_log.push_back(int'(ra)); exp_log.push_back(256); exp_log.push_back('h45);
      exp_log.push_back(768); exp_log.push_back(769); exp_log.push_back(512);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge where done is seen
  // with cyc = cycles since the accept cycle (-1 on timeout).
  task automatic run_txn(input bit r, input logic [7:0] ra, input logic [15:0] wd,
                         input bit hold, input int glitch_at, output int cyc);
    int n;
    n = 0; cyc = -1;
    rnw = r; reg_addr = ra; wr_data = wd; start = 1'b1;
    while (n < 2000 && cyc < 0) begin
      @(negedge CLK); n++;
      if (n == 1 && !hold) start = 1'b0;
      if (glitch_at != 0 && n == glitch_at) begin
        start = 1'b1; rnw = ~r; reg_addr = 8'h77; wr_data = 16'h1111;
      end
      if (glitch_at != 0 && n == glitch_at + 1) begin
        start = 1'b0; rnw = r; reg_addr = ra; wr_data = wd;
      end
      if (done) cyc = n;
    end
  endtask

  typedef struct {
    bit          rnw;
    logic [7:0]  ra;
    logic [15:0] wd;
    bit          nack;
    int          cyc;
    bit          err;
    logic [15:0] rd;
  } vec_t;

  vec_t vt[8];

  initial begin
    int cyc, n, ndone;
    bit ps, pd, found;

    vt[0] = '{1'b1, 8'h05, 16'h0000, 1'b0, 384, 1'b0, 16'h1234};
    vt[1] = '{1'b0, 8'h05, 16'hABCD, 1'b0, 304, 1'b0, 16'h1234};
    vt[2] = '{1'b1, 8'h05, 16'h0000, 1'b0, 384, 1'b0, 16'hABCD};
    vt[3] = '{1'b1, 8'h05, 16'h0000, 1'b1,  88, 1'b1, 16'hABCD};
    vt[4] = '{1'b0, 8'hA5, 16'h0001, 1'b0, 304, 1'b0, 16'hABCD};
    vt[5] = '{1'b1, 8'hA5, 16'h0000, 1'b0, 384, 1'b0, 16'h0001};
    vt[6] = '{1'b0, 8'h05, 16'h7777, 1'b1,  88, 1'b1, 16'h0001};
    vt[7] = '{1'b1, 8'h05, 16'h0000, 1'b0, 384, 1'b0, 16'hABCD};

    for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
    regs[5] = 16'h1234;

    Reset = 1'b0; start = 1'b0; rnw = 1'b0; reg_addr = '0; wr_data = '0;
    repeat (3) @(negedge CLK);
    check("reset SCL", SCL, 1);
    check("reset oSDA", oSDA, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ack_err", ack_err, 0);
    check("reset rd_data", rd_data, 0);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);

    foreach (vt[i]) begin
      nack_addr = vt[i].nack;
      blog.delete();
      build_exp(vt[i].rnw, vt[i].ra, vt[i].wd, vt[i].nack);
      run_txn(vt[i].rnw, vt[i].ra, vt[i].wd, 1'b0, 0, cyc);
      check($sformatf("v%0d cycles", i), cyc, vt[i].cyc);
      check($sformatf("v%0d busy at done", i), busy, 0);
      check($sformatf("v%0d ack_err", i), ack_err, vt[i].err);
      check($sformatf("v%0d rd_data", i), rd_data, vt[i].rd);
      @(negedge CLK);
      check($sformatf("v%0d done pulse width", i), done, 0);
      check($sformatf("v%0d bus log", i), log_ok(), 1);
      if (!vt[i].rnw && !vt[i].nack)
        check($sformatf("v%0d slave reg", i), regs[vt[i].ra], vt[i].wd);
      repeat (2) @(negedge CLK);
    end
    nack_addr = 1'b0;

    // start pulsed mid-write is ignored
    blog.delete();
    build_exp(1'b0, 8'h33, 16'h1357, 1'b0);
    run_txn(1'b0, 8'h33, 16'h1357, 1'b0, 100, cyc);
    check("ignored start cycles", cyc, 304);
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (done || busy) ndone++;
    end
    check("ignored start no 2nd txn", ndone, 0);
    check("ignored start bus log", log_ok(), 1);
    check("ignored start slave reg", regs[8'h33], 16'h1357);

    // async reset mid data byte
    rnw = 1'b0; reg_addr = 8'h44; wr_data = 16'hAB00; start = 1'b1;
    for (int k = 0; k < 160; k++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    check("pre-reset busy", busy, 1);
    Reset = 1'b0;
    #1;
    check("mid reset SCL", SCL, 1);
    check("mid reset oSDA", oSDA, 1);
    check("mid reset busy", busy, 0);
    check("mid reset rd_data", rd_data, 0);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    blog.delete();
    build_exp(1'b0, 8'h05, 16'hBEEF, 1'b0);
    run_txn(1'b0, 8'h05, 16'hBEEF, 1'b0, 0, cyc);
    check("post-reset cycles", cyc, 304);
    check("post-reset ack_err", ack_err, 0);
    @(negedge CLK);
    check("post-reset bus log", log_ok(), 1);
    check("post-reset slave reg", regs[8'h05], 16'hBEEF);
    repeat (2) @(negedge CLK);

    // back-to-back with start held through done
    run_txn(1'b0, 8'h10, 16'h5A5A, 1'b1, 0, cyc);
    check("b2b first cycles", cyc, 304);
    rnw = 1'b1; reg_addr = 8'h10;
    blog.delete();
    build_exp(1'b1, 8'h10, 16'h0000, 1'b0);
    ps = SCL; pd = oSDA; found = 1'b0; n = 0; cyc = -1;
    while (n < 2000 && cyc < 0) begin
      @(negedge CLK); n++;
      if (n == 1) begin
        check("b2b busy next cycle", busy, 1);
        start = 1'b0;
      end
      if (n <= 8 && ps && SCL && pd && !oSDA) found = 1'b1;
      ps = SCL; pd = oSDA;
      if (done) cyc = n;
    end
    check("b2b START condition", found, 1);
    check("b2b second cycles", cyc, 384);
    check("b2b rd_data", rd_data, 16'h5A5A);
    @(negedge CLK);
    check("b2b bus log", log_ok(), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
